router_sched: RTL and testbench

Central scheduler for the 16-port serial router. Each input port deserialises a packet and raises a valid flag carrying a 4-bit destination address and a 32-bit payload. This block arbitrates, per output port, among all inputs currently targeting that output. It uses round-robin priority, hands the winning payload to the output side, and returns a one-cycle `granted` pulse to the winning input so it can clear its valid flag.

---
 rtl/router_pkg.sv | 14 +
 rtl/rr_arb.sv | 28 ++
 rtl/router_sched.sv | 125 ++++++++++++
 tb/tb_router_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and types for the 16-port router scheduler.
// Port count must stay a power of two so index math wraps for free.
package router_pkg;

  localparam int NPORTS = 16;
  localparam int AW     = 4;
  localparam int DW     = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: searches ptr+1 upward,
// wrapping, with ptr itself considered last.
module rr_arb #(
  parameter int NPORTS = 16,
  parameter int AW     = 4
) (
  input  logic [NPORTS-1:0] req,
  input  logic [AW-1:0]     ptr,
  output logic [AW-1:0]     winner,
  output logic              found
);

  always_comb begin
    logic [AW-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      // AW-bit add wraps modulo NPORTS; k == NPORTS lands on ptr
      idx = ptr + AW'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/router_sched.sv
// Per-output round-robin scheduler with IDLE/HOLD handshake
// and a registered one-cycle grant pulse back to the inputs.
module router_sched
  import router_pkg::*;
#(
  parameter int NPORTS = router_pkg::NPORTS,
  parameter int AW     = router_pkg::AW,
  parameter int DW     = router_pkg::DW
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NPORTS-1:0]    in_vld,
  input  logic [NPORTS*AW-1:0] in_addr,
  input  logic [NPORTS*DW-1:0] in_payload,
  output logic [NPORTS-1:0]    granted,
  output logic [NPORTS-1:0]    out_vld,
  output logic [NPORTS*DW-1:0] out_payload,
  output logic [NPORTS*AW-1:0] out_src,
  input  logic [NPORTS-1:0]    out_ack
);

  logic [NPORTS-1:0] granted_q;
  logic [NPORTS-1:0] granted_d;

  logic [NPORTS-1:0][NPORTS-1:0] gnt_vec;

  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    logic [NPORTS-1:0] req;
    logic [AW-1:0]     win;
    logic              found;
    logic              take;
    sched_state_t      st_q, st_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]     src_q, src_d;
    logic              vld_q, vld_d;
    logic [DW-1:0]     pay_q, pay_d;

    // granted_q mask stops a second win while the input clears
    always_comb begin
      req = '0;
      for (int i = 0; i < NPORTS; i++) begin
        req[i] = in_vld[i]
               && (in_addr[i*AW +: AW] == AW'(o))
               && !granted_q[i];
      end
    end

    rr_arb #(
      .NPORTS (NPORTS),
      .AW     (AW)
    ) u_arb (
      .req    (req),
      .ptr    (ptr_q),
      .winner (win),
      .found  (found)
    );

    assign take = (st_q == IDLE) && found;

    always_comb begin
      st_d  = st_q;
      ptr_d = ptr_q;
      src_d = src_q;
      vld_d = vld_q;
      pay_d = pay_q;
      unique case (st_q)
        IDLE: begin
          if (found) begin
            st_d  = HOLD;
            ptr_d = win;
            src_d = win;
            vld_d = 1'b1;
            pay_d = in_payload[win*DW +: DW];
          end
        end
        HOLD: begin
          if (out_ack[o]) begin
            st_d  = IDLE;
            vld_d = 1'b0;
          end
        end
        default: st_d = IDLE;
      endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        st_q  <= IDLE;
        ptr_q <= AW'(NPORTS - 1);
        src_q <= '0;
        vld_q <= 1'b0;
        pay_q <= '0;
      end else begin
        st_q  <= st_d;
        ptr_q <= ptr_d;
        src_q <= src_d;
        vld_q <= vld_d;
        pay_q <= pay_d;
      end
    end

    assign gnt_vec[o] = take ? (NPORTS'(1) << win) : '0;
    assign out_vld[o] = vld_q;
    assign out_payload[o*DW +: DW] = pay_q;
    assign out_src[o*AW +: AW]     = src_q;
  end

  always_comb begin
    granted_d = '0;
    for (int o = 0; o < NPORTS; o++) begin
      granted_d = granted_d | gnt_vec[o];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      granted_q <= '0;
    end else begin
      granted_q <= granted_d;
    end
  end

  assign granted = granted_q;

endmodule

// File: tb/tb_router_sched.sv
// Bench for router_sched: directed scenarios plus a randomized run
// against a per-output round-robin reference model.
module tb_router_sched;
  import router_pkg::*;

  localparam int N = NPORTS;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    in_vld;
  logic [N*AW-1:0] in_addr;
  logic [N*DW-1:0] in_payload;
  logic [N-1:0]    granted;
  logic [N-1:0]    out_vld;
  logic [N*DW-1:0] out_payload;
  logic [N*AW-1:0] out_src;
  logic [N-1:0]    out_ack;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  logic [N-1:0]    m_vld;
  logic [N-1:0]    m_gnt;
  logic [N*DW-1:0] m_pay;
  logic [N*AW-1:0] m_src;
  int              m_ptr [N];

  always #5 clock = ~clock;

  router_sched #(
    .NPORTS (N),
    .AW     (AW),
    .DW     (DW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_vld      (in_vld),
    .in_addr     (in_addr),
    .in_payload  (in_payload),
    .granted     (granted),
    .out_vld     (out_vld),
    .out_payload (out_payload),
    .out_src     (out_src),
    .out_ack     (out_ack)
  );

  task automatic model_reset();
    m_vld = '0;
    m_gnt = '0;
    m_pay = '0;
    m_src = '0;
    for (int o = 0; o < N; o++) m_ptr[o] = N - 1;
  endtask

  // One rising edge: model computes next state from current inputs.
  task automatic tick();
    logic [N-1:0]    nv;
    logic [N-1:0]    ng;
    logic [N*DW-1:0] np;
    logic [N*AW-1:0] ns;
    nv = m_vld;
    ng = '0;
    np = m_pay;
    ns = m_src;
    for (int o = 0; o < N; o++) begin
      if (m_vld[o]) begin
        if (out_ack[o]) nv[o] = 1'b0;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_ptr[o] + k) % N;
          if (in_vld[i] && int'(in_addr[i*AW +: AW]) == o
              && !m_gnt[i]) begin
            nv[o] = 1'b1;
            np[o*DW +: DW] = in_payload[i*DW +: DW];
            ns[o*AW +: AW] = AW'(i);
            ng[i] = 1'b1;
            m_ptr[o] = i;
            break;
          end
        end
      end
    end
    @(posedge clock);
    #1;
    m_vld = nv;
    m_gnt = ng;
    m_pay = np;
    m_src = ns;
  endtask

  task automatic set_in(input int i, input int a, input logic [DW-1:0] p);
    in_vld[i] = 1'b1;
    in_addr[i*AW +: AW] = AW'(a);
    in_payload[i*DW +: DW] = p;
  endtask

  task automatic drain();
    in_vld  = '0;
    out_ack = '1;
    tick();
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_vld  = '0;
    out_ack = '0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b1;
    in_vld     = N'($urandom);
    in_addr    = {$urandom, $urandom};
    in_payload = '1;
    out_ack    = N'($urandom);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (out_vld !== '0) begin
      errors++;
      $display("FAIL reset_vld got %h want 0", out_vld);
    end
    vectors++;
    if (granted !== '0) begin
      errors++;
      $display("FAIL reset_gnt got %h want 0", granted);
    end
    vectors++;
    if (out_payload !== '0) begin
      errors++;
      $display("FAIL reset_pay got %h want 0", out_payload);
    end
    vectors++;
    if (out_src !== '0) begin
      errors++;
      $display("FAIL reset_src got %h want 0", out_src);
    end
    in_vld  = '0;
    out_ack = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    set_in(0, 0, 32'h0000_0A00);
    set_in(1, 0, 32'h0000_0A01);
    tick();
    vectors++;
    if (out_src[0 +: AW] !== 4'd0 || granted !== 16'h0001) begin
      errors++;
      $display("FAIL reset_prio src %0d gnt %h want 0 0001",
               out_src[0 +: AW], granted);
    end
    drain();
  endtask

  task automatic test_single();
    out_ack = '0;
    set_in(3, 5, 32'hDEAD_BEEF);
    tick();
    in_vld[3] = 1'b0;
    vectors++;
    if (out_vld[5] !== 1'b1 || out_payload[5*DW +: DW] !== 32'hDEAD_BEEF
        || out_src[5*AW +: AW] !== 4'd3) begin
      errors++;
      $display("FAIL single vld %b pay %h src %0d want 1 deadbeef 3",
               out_vld[5], out_payload[5*DW +: DW], out_src[5*AW +: AW]);
    end
    vectors++;
    if (granted !== 16'h0008) begin
      errors++;
      $display("FAIL single_gnt got %h want 0008", granted);
    end
    tick();
    vectors++;
    if (granted !== '0 || out_vld[5] !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse gnt %h vld %b want 0000 1",
               granted, out_vld[5]);
    end
    drain();
  endtask

  task automatic test_round_robin();
    int order [3];
    order = '{2, 7, 9};
    do_reset();
    out_ack = '0;
    out_ack[4] = 1'b1;
    set_in(2, 4, 32'h2);
    set_in(7, 4, 32'h7);
    set_in(9, 4, 32'h9);
    for (int j = 0; j < 3; j++) begin
      tick();
      vectors++;
      if (out_vld[4] !== 1'b1 || int'(out_src[4*AW +: AW]) != order[j]) begin
        errors++;
        $display("FAIL rr_%0d vld %b src %0d want 1 %0d",
                 j, out_vld[4], out_src[4*AW +: AW], order[j]);
      end
      in_vld[order[j]] = 1'b0;
      tick();
      vectors++;
      if (out_vld[4] !== 1'b0) begin
        errors++;
        $display("FAIL rr_ack_%0d vld %b want 0", j, out_vld[4]);
      end
    end
    set_in(2, 4, 32'h22);
    set_in(10, 4, 32'h10);
    tick();
    vectors++;
    if (out_src[4*AW +: AW] !== 4'd10) begin
      errors++;
      $display("FAIL rr_wrap src %0d want 10", out_src[4*AW +: AW]);
    end
    in_vld[10] = 1'b0;
    tick();
    tick();
    vectors++;
    if (out_src[4*AW +: AW] !== 4'd2 || out_payload[4*DW +: DW] !== 32'h22) begin
      errors++;
      $display("FAIL rr_next src %0d pay %h want 2 22",
               out_src[4*AW +: AW], out_payload[4*DW +: DW]);
    end
    drain();
  endtask

  task automatic test_parallel();
    out_ack = '0;
    set_in(1, 0, 32'h1111);
    set_in(2, 15, 32'h2222);
    tick();
    in_vld = '0;
    vectors++;
    if (out_vld !== 16'h8001 || granted !== 16'h0006) begin
      errors++;
      $display("FAIL parallel vld %h gnt %h want 8001 0006",
               out_vld, granted);
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ack = '0;
    set_in(5, 4, 32'hCAFE_0005);
    tick();
    in_vld[5] = 1'b0;
    set_in(6, 4, 32'hCAFE_0006);
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (out_vld[4] !== 1'b1 || out_payload[4*DW +: DW] !== 32'hCAFE_0005
          || granted[6] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d vld %b pay %h g6 %b", c,
                 out_vld[4], out_payload[4*DW +: DW], granted[6]);
      end
    end
    out_ack[4] = 1'b1;
    tick();
    vectors++;
    if (out_vld[4] !== 1'b0 || granted[6] !== 1'b0) begin
      errors++;
      $display("FAIL bp_ack vld %b g6 %b want 0 0", out_vld[4], granted[6]);
    end
    out_ack[4] = 1'b0;
    tick();
    vectors++;
    if (granted[6] !== 1'b1 || out_src[4*AW +: AW] !== 4'd6) begin
      errors++;
      $display("FAIL bp_next g6 %b src %0d want 1 6",
               granted[6], out_src[4*AW +: AW]);
    end
    drain();
  endtask

  task automatic test_reset_mid_hold();
    out_ack = '0;
    set_in(3, 4, 32'hABCD_0003);
    tick();
    in_vld = '0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (out_vld !== '0 || granted !== '0 || out_payload !== '0
        || out_src !== '0) begin
      errors++;
      $display("FAIL mid_hold_reset vld %h gnt %h src %h",
               out_vld, granted, out_src);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    set_in(8, 4, 32'h8);
    set_in(1, 4, 32'h1);
    tick();
    vectors++;
    if (out_src[4*AW +: AW] !== 4'd1 || granted !== 16'h0002) begin
      errors++;
      $display("FAIL mid_hold_ptr src %0d gnt %h want 1 0002",
               out_src[4*AW +: AW], granted);
    end
    drain();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_vld[i] && $urandom_range(0, 2) == 0) begin
          set_in(i, int'($urandom_range(0, 5)), $urandom);
        end else if (in_vld[i] && $urandom_range(0, 19) == 0) begin
          in_vld[i] = 1'b0;
        end else if (in_vld[i] && $urandom_range(0, 19) == 0) begin
          in_addr[i*AW +: AW] = AW'($urandom_range(0, N - 1));
        end
      end
      out_ack = N'($urandom);
      tick();
      vectors++;
      if (out_vld !== m_vld) begin
        errors++;
        $display("FAIL rand_vld cyc %0d got %h want %h", c, out_vld, m_vld);
      end
      vectors++;
      if (granted !== m_gnt) begin
        errors++;
        $display("FAIL rand_gnt cyc %0d got %h want %h", c, granted, m_gnt);
      end
      vectors++;
      if (out_src !== m_src) begin
        errors++;
        $display("FAIL rand_src cyc %0d got %h want %h", c, out_src, m_src);
      end
      vectors++;
      if (out_payload !== m_pay) begin
        errors++;
        $display("FAIL rand_pay cyc %0d got %h want %h",
                 c, out_payload, m_pay);
      end
      in_vld = in_vld & ~m_gnt;
    end
    drain();
  endtask

  initial begin
    reset_n    = 1'b1;
    in_vld     = '0;
    in_addr    = '0;
    in_payload = '0;
    out_ack    = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_parallel();
    test_backpressure();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
